serializer_tx_scheduler: RTL

//   Round-robin scheduler that shares one serializer (Aurora TX framer) between NUM_REQ

---
 rtl/serializer_tx_scheduler.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serializer_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : serializer_tx_scheduler
// Description : Round-robin arbiter that shares one serializer between
//               NUM_REQ requesters and tracks completion or timeout per grant.
// Revision    : 1.0 - initial release
// ============================================================================
module serializer_tx_scheduler #(
    parameter int NUM_REQ         = 4,
    parameter int SEND_DATA_WIDTH = 1024,
    parameter int ADDR_WIDTH      = 10,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ*SEND_DATA_WIDTH-1:0]  req_data,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_dst_addr,
    input  logic [NUM_REQ*2-1:0]                req_ttl,
    input  logic [NUM_REQ*2-1:0]                req_router_id,
    output logic [NUM_REQ-1:0]                  req_ack,
    output logic [NUM_REQ-1:0]                  req_err,
    output logic                                send_data_valid,
    output logic [SEND_DATA_WIDTH-1:0]          v_data_read,
    output logic [ADDR_WIDTH-1:0]               dst_addr_send,
    output logic [1:0]                          TTL_send,
    output logic [1:0]                          router_id_send,
    input  logic                                done_serializer,
    output logic                                busy,
    output logic [$clog2(NUM_REQ)-1:0]          grant_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDW-1:0]     rr_ptr;
    logic [CW-1:0]      cnt;
    logic               win_found;
    logic [IDW-1:0]     win_idx;
    logic [IDW-1:0]     scan_idx;
    logic               timeout_hit;
    logic [NUM_REQ-1:0] grant_onehot;

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = IDW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!win_found && req_valid[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign timeout_hit  = (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign grant_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id;
    assign busy         = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (win_found) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (done_serializer || timeout_hit) state_nxt = S_GAP;
            S_GAP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr          <= '0;
            cnt             <= '0;
            grant_id        <= '0;
            send_data_valid <= 1'b0;
            req_ack         <= '0;
            req_err         <= '0;
            v_data_read     <= '0;
            dst_addr_send   <= '0;
            TTL_send        <= '0;
            router_id_send  <= '0;
        end else begin
            send_data_valid <= 1'b0;
            req_ack         <= '0;
            req_err         <= '0;
            case (state)
                S_IDLE: begin
                    if (win_found) begin
                        grant_id        <= win_idx;
                        send_data_valid <= 1'b1;
                        v_data_read     <= req_data[int'(win_idx)*SEND_DATA_WIDTH +: SEND_DATA_WIDTH];
                        dst_addr_send   <= req_dst_addr[int'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                        TTL_send        <= req_ttl[int'(win_idx)*2 +: 2];
                        router_id_send  <= req_router_id[int'(win_idx)*2 +: 2];
                    end
                end
                S_WAIT: begin
                    // Completion takes priority over a coincident timeout.
                    if (done_serializer) begin
                        req_ack <= grant_onehot;
                    end else if (timeout_hit) begin
                        req_err <= grant_onehot;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    cnt    <= '0;
                    rr_ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
